// File: rtl/sram_arbiter.sv
// Shares one external async SRAM between the fixed-slot Oric core (port A)
// and a req/ack DMA loader (port B) that only uses the gaps where aSlot is low.
module sram_arbiter #(
  parameter int AW  = 19,
  parameter int DW  = 8,
  parameter int WEW = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          aSlot,
  input  logic          aWe,
  input  logic [AW-1:0] aA,
  input  logic [DW-1:0] aD,
  output logic [DW-1:0] aQ,
  input  logic          bReq,
  input  logic          bWe,
  input  logic [AW-1:0] bA,
  input  logic [DW-1:0] bD,
  output logic [DW-1:0] bQ,
  output logic          bAck,
  input  logic [DW-1:0] sramQ,
  output logic [AW-1:0] sramA,
  output logic [DW-1:0] sramD,
  output logic          sramDrv,
  output logic          sramWe,
  output logic [2:0]    fsm_state
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] B_ADDR  = 3'd1;
  localparam logic [2:0] B_PULSE = 3'd2;
  localparam logic [2:0] B_HOLD  = 3'd3;
  localparam logic [2:0] B_WAIT  = 3'd4;

  localparam int            CW       = (WEW > 1) ? $clog2(WEW) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WEW - 1);

  logic [2:0]    state;
  logic [CW-1:0] cnt;

  // Any edge with aSlot high inside a B access abandons it; B_WAIT retries from scratch.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      bAck  <= 1'b0;
      bQ    <= '0;
    end else begin
      bAck <= 1'b0;
      case (state)
        IDLE: begin
          if (bReq && !aSlot) state <= B_ADDR;
        end
        B_WAIT: begin
          if (!aSlot) state <= B_ADDR;
        end
        B_ADDR: begin
          if (aSlot) begin
            state <= B_WAIT;
          end else begin
            state <= B_PULSE;
            cnt   <= CNT_LOAD;
          end
        end
        B_PULSE: begin
          if (aSlot) begin
            state <= B_WAIT;
          end else if (cnt == '0) begin
            state <= B_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        B_HOLD: begin
          if (aSlot) begin
            state <= B_WAIT;
          end else begin
            state <= IDLE;
            bAck  <= 1'b1;
            if (!bWe) bQ <= sramQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Port A has zero-latency priority; reset overrides everything so no stray write strobe.
  always_comb begin
    sramA   = aA;
    sramD   = aD;
    sramWe  = 1'b1;
    sramDrv = 1'b0;
    if (aSlot) begin
      sramWe  = ~aWe;
      sramDrv = aWe;
    end else begin
      case (state)
        B_ADDR, B_HOLD: begin
          sramA   = bA;
          sramD   = bD;
          sramDrv = bWe;
        end
        B_PULSE: begin
          sramA   = bA;
          sramD   = bD;
          sramDrv = bWe;
          sramWe  = ~bWe;
        end
        default: ;
      endcase
    end
    if (!reset) begin
      sramWe  = 1'b1;
      sramDrv = 1'b0;
    end
  end

  assign aQ        = sramQ;
  assign fsm_state = state;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural async SRAM on the pins.
module tb_sram_arbiter;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic        clock, reset, aSlot, aWe, bReq, bWe, bAck, sramDrv, sramWe;
  logic [18:0] aA, bA, sramA;
  logic [7:0]  aD, aQ, bD, bQ, sramQ, sramD;
  logic [2:0]  fsm_state;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mem [0:(1<<19)-1];

  sram_arbiter #(.AW(19), .DW(8), .WEW(2)) dut (
    .clock(clock), .reset(reset), .aSlot(aSlot), .aWe(aWe), .aA(aA), .aD(aD),
    .aQ(aQ), .bReq(bReq), .bWe(bWe), .bA(bA), .bD(bD), .bQ(bQ), .bAck(bAck),
    .sramQ(sramQ), .sramA(sramA), .sramD(sramD), .sramDrv(sramDrv),
    .sramWe(sramWe), .fsm_state(fsm_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Simple async SRAM: a low write strobe over a clock period stores the data.
  always @(posedge clock) begin
    if (sramWe === 1'b0 && sramDrv === 1'b1) mem[sramA] <= sramD;
  end
  assign sramQ = mem[sramA];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One B access from the current cycle; bReq drops in the bAck cycle.
  task automatic b_access(input logic we, input logic [18:0] addr, input logic [7:0] data,
                          output int lat, output int we_low, output int drv_cnt,
                          output logic [18:0] a_seen, output logic [7:0] d_seen);
    bReq = 1'b1; bWe = we; bA = addr; bD = data;
    lat = 0; we_low = 0; drv_cnt = 0; a_seen = '0; d_seen = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) begin a_seen = sramA; d_seen = sramD; end
      if (sramWe === 1'b0) we_low++;
      if (sramDrv === 1'b1) drv_cnt++;
      if (bAck === 1'b1) begin
        lat = c;
        bReq = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    int lat, we_low, drv_cnt, n_ack, a1, a2, a3, ack_seen;
    logic [18:0] a_seen;
    logic [7:0]  d_seen;

    for (int i = 0; i < (1 << 19); i++) mem[i] = 8'h00;
    reset = 1'b0; aSlot = 1'b1; aWe = 1'b1; aA = 19'h00010; aD = 8'hFF;
    bReq = 1'b0; bWe = 1'b0; bA = '0; bD = '0;

    // reset held with port A asking to write
    repeat (3) tick();
    check("rst_we", sramWe, 1'b1);
    check("rst_drv", sramDrv, 1'b0);
    check("rst_ack", bAck, 1'b0);
    check("rst_bq", bQ, 8'h00);
    check("rst_state", fsm_state, S_IDLE);

    reset = 1'b1; aSlot = 1'b0; aWe = 1'b0;
    tick();

    // B write of A5 to 0C000
    b_access(1'b1, 19'h0C000, 8'hA5, lat, we_low, drv_cnt, a_seen, d_seen);
    check("wr_lat", lat, 5);
    check("wr_we_low", we_low, 2);
    check("wr_drv", drv_cnt, 4);
    check("wr_addr", a_seen, 19'h0C000);
    check("wr_data", d_seen, 8'hA5);
    check("wr_mem", mem[19'h0C000], 8'hA5);

    // B read back
    b_access(1'b0, 19'h0C000, 8'h00, lat, we_low, drv_cnt, a_seen, d_seen);
    check("rd_lat", lat, 5);
    check("rd_bq", bQ, 8'hA5);
    check("rd_we_low", we_low, 0);
    check("rd_drv", drv_cnt, 0);

    // port A write while B requests simultaneously: A wins, same-cycle mux
    aSlot = 1'b1; aWe = 1'b1; aA = 19'h01234; aD = 8'h3C;
    bReq = 1'b1; bWe = 1'b0; bA = 19'h0C000;
    #1;
    check("a_addr", sramA, 19'h01234);
    check("a_we", sramWe, 1'b0);
    check("a_drv", sramDrv, 1'b1);
    check("a_data", sramD, 8'h3C);
    check("a_q_before", aQ, 8'h00);
    tick();
    check("a_q_after", aQ, 8'h3C);
    check("a_wins_state", fsm_state, S_IDLE);
    check("a_wins_ack", bAck, 1'b0);
    aSlot = 1'b0; aWe = 1'b0;
    b_access(1'b0, 19'h0C000, 8'h00, lat, we_low, drv_cnt, a_seen, d_seen);
    check("after_a_lat", lat, 5);
    check("after_a_bq", bQ, 8'hA5);

    // abort in the second B_PULSE clock, then full retry
    bReq = 1'b1; bWe = 1'b1; bA = 19'h0C001; bD = 8'h5A;
    repeat (3) tick();
    check("ab_state_pulse", fsm_state, S_PULSE);
    aSlot = 1'b1; aWe = 1'b0; aA = 19'h00777;
    #1;
    check("ab_a_addr", sramA, 19'h00777);
    check("ab_a_we", sramWe, 1'b1);
    check("ab_a_drv", sramDrv, 1'b0);
    ack_seen = 0;
    tick();
    if (bAck === 1'b1) ack_seen++;
    check("ab_state_wait", fsm_state, S_WAIT);
    repeat (2) begin
      tick();
      if (bAck === 1'b1) ack_seen++;
    end
    check("ab_no_ack", ack_seen, 0);
    aSlot = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bAck === 1'b1) begin lat = c; bReq = 1'b0; break; end
    end
    check("ab_retry_lat", lat, 5);
    check("ab_mem", mem[19'h0C001], 8'h5A);
    b_access(1'b0, 19'h0C001, 8'h00, lat, we_low, drv_cnt, a_seen, d_seen);
    check("ab_rd_bq", bQ, 8'h5A);

    // bReq held high: three back-to-back reads
    bReq = 1'b1; bWe = 1'b0; bA = 19'h0C000;
    n_ack = 0; a1 = 0; a2 = 0; a3 = 0;
    for (int c = 1; c <= 40 && n_ack < 3; c++) begin
      tick();
      if (bAck === 1'b1) begin
        n_ack++;
        if (n_ack == 1) a1 = c;
        else if (n_ack == 2) a2 = c;
        else begin a3 = c; bReq = 1'b0; end
      end
    end
    check("b2b_ack1", a1, 5);
    check("b2b_ack2", a2, 10);
    check("b2b_ack3", a3, 15);
    check("b2b_bq", bQ, 8'hA5);

    // reset asserted mid-write
    bReq = 1'b1; bWe = 1'b1; bA = 19'h0C002; bD = 8'h77;
    repeat (2) tick();
    check("mr_pulse_we", sramWe, 1'b0);
    reset = 1'b0; bReq = 1'b0;
    #1;
    check("mr_we_now", sramWe, 1'b1);
    tick();
    check("mr_we_next", sramWe, 1'b1);
    check("mr_state", fsm_state, S_IDLE);
    check("mr_ack", bAck, 1'b0);
    check("mr_bq", bQ, 8'h00);
    tick();
    reset = 1'b1;
    ack_seen = 0;
    repeat (8) begin
      tick();
      if (bAck === 1'b1) ack_seen++;
    end
    check("mr_no_ack", ack_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
